// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared types for the camera pixel to AXI4-Stream bridge
// Purpose: pixel width, frame-state encoding and FIFO entry layout used by
//          cam_pixel_axis_bridge and its helpers.
package cam_pkg;

    localparam int PIX_W = 24;

    typedef enum logic [2:0] {
        WAIT_VS = 3'd0,
        BLANK   = 3'd1,
        ARMED   = 3'd2,
        ACTIVE  = 3'd3,
        DROP    = 3'd4
    } frame_state_e;

    // Queued beat layout; the bridge packs its FIFO words in this same order
    // ({sof, eol, data}) for any DATA_W.
    typedef struct packed {
        logic             sof;
        logic             eol;
        logic [PIX_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with a registered output head
// Purpose: stores up to DEPTH words; the oldest word sits in an output
//          register so downstream sees flop-driven data.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   wr_en, wr_data  push request and word (ignored when full without a pop)
//   full            DEPTH words held (head register included)
//   rd_en           pop the head when it is valid
//   rd_data         head word
//   empty           head register holds nothing
module sync_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      mem_cnt_q, mem_cnt_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             head_vld_q, head_vld_d;

    logic pop, push, refill, take, bypass, mem_wr;

    // Capacity counts the head register, so DEPTH words total fit.
    assign full  = (mem_cnt_q + (AW+1)'(head_vld_q)) == (AW+1)'(DEPTH);
    assign empty = ~head_vld_q;
    assign rd_data = head_q;

    assign pop  = head_vld_q & rd_en;
    assign push = wr_en & (~full | pop);

    always_comb begin
        refill     = ~head_vld_q | pop;
        take       = refill & (mem_cnt_q != '0);
        // An empty store lets a push land straight in the head register;
        // it still shows up only after the clock edge.
        bypass     = refill & (mem_cnt_q == '0) & push;
        mem_wr     = push & ~bypass;

        head_d     = head_q;
        head_vld_d = head_vld_q & ~pop;
        if (take) begin
            head_d     = mem_q[rd_ptr_q];
            head_vld_d = 1'b1;
        end else if (bypass) begin
            head_d     = wr_data;
            head_vld_d = 1'b1;
        end

        wr_ptr_d  = mem_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = take ? rd_ptr_q + AW'(1) : rd_ptr_q;
        mem_cnt_d = mem_cnt_q + (AW+1)'(mem_wr) - (AW+1)'(take);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_cnt_q  <= '0;
            head_q     <= '0;
            head_vld_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_cnt_q  <= mem_cnt_d;
            head_q     <= head_d;
            head_vld_q <= head_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/cam_pixel_axis_bridge.sv
// rtl/cam_pixel_axis_bridge.sv - camera pixel stream to AXI4-Stream video bridge
// Purpose: re-times a capture-stage pixel stream (valid strobe plus trailing
//          last pulse) into AXI4-Stream video with tuser=SOF and tlast=EOL,
//          buffering in a FIFO and dropping whole frames on overflow.
// Ports:
//   pclk, rst_n               pixel clock, asynchronous active-low reset
//   vsync                     high during vertical blanking
//   pix_data/pix_valid        pixel and its one-cycle strobe
//   pix_last                  one-cycle pulse after a line's final pixel
//   m_axis_tdata/tvalid/tready/tuser/tlast   AXI4-Stream master
//   frame_dropped             one-cycle pulse when a frame is abandoned
//   frame_cnt, drop_cnt       emitted-frame and dropped-frame counters,
//                             present only with CAM_BRIDGE_STATS_EN defined
module cam_pixel_axis_bridge
    import cam_pkg::*;
#(
    parameter int DATA_W = PIX_W,
    parameter int DEPTH  = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              vsync,
    input  logic [DATA_W-1:0] pix_data,
    input  logic              pix_valid,
    input  logic              pix_last,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tuser,
    output logic              m_axis_tlast,
`ifdef CAM_BRIDGE_STATS_EN
    output logic [15:0]       frame_cnt,
    output logic [15:0]       drop_cnt,
`endif
    output logic              frame_dropped
);

    frame_state_e      state_q, state_d;
    logic              vsync_q, vsync_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic              hold_vld_q, hold_vld_d;
    logic              hold_sof_q, hold_sof_d;
    logic              pend_eol_q, pend_eol_d;
    logic              drop_q, drop_d;

    logic              vs_rise, vs_fall;
    logic              push_req, push_eol, push_ok;
    logic              fifo_full, fifo_empty, fifo_pop;
    logic [DATA_W+1:0] fifo_rd_data;

    assign vs_rise  = vsync & ~vsync_q;
    assign vs_fall  = ~vsync & vsync_q;
    assign fifo_pop = ~fifo_empty & m_axis_tready;
    assign push_ok  = ~fifo_full | fifo_pop;

    // Every push writes the holding register: a pixel's eol is only known
    // once the next valid or the trailing last pulse arrives.
    always_comb begin
        state_d     = state_q;
        vsync_d     = vsync;
        hold_data_d = hold_data_q;
        hold_vld_d  = hold_vld_q;
        hold_sof_d  = hold_sof_q;
        pend_eol_d  = pend_eol_q;
        drop_d      = 1'b0;
        push_req    = 1'b0;
        push_eol    = 1'b0;

        case (state_q)
            WAIT_VS: begin
                hold_vld_d = 1'b0;
                pend_eol_d = 1'b0;
                if (vsync) state_d = BLANK;
            end
            BLANK: begin
                if (vs_fall) state_d = ARMED;
            end
            ARMED: begin
                // A blanking interval with no pixels simply re-arms.
                if (vsync) begin
                    state_d = BLANK;
                end else if (pix_valid) begin
                    hold_data_d = pix_data;
                    hold_vld_d  = 1'b1;
                    hold_sof_d  = 1'b1;
                    pend_eol_d  = pix_last;
                    state_d     = ACTIVE;
                end
            end
            ACTIVE: begin
                if (vs_rise) begin
                    // Close the frame: the held pixel ends the last line.
                    push_req   = hold_vld_q;
                    push_eol   = 1'b1;
                    hold_vld_d = 1'b0;
                    pend_eol_d = 1'b0;
                    state_d    = BLANK;
                end else if (pend_eol_q) begin
                    // Second half of a coincident valid+last.
                    push_req   = 1'b1;
                    push_eol   = 1'b1;
                    hold_vld_d = 1'b0;
                    pend_eol_d = 1'b0;
                    if (pix_valid) begin
                        hold_data_d = pix_data;
                        hold_vld_d  = 1'b1;
                        hold_sof_d  = 1'b0;
                        pend_eol_d  = pix_last;
                    end
                end else if (pix_valid) begin
                    push_req    = hold_vld_q;
                    push_eol    = 1'b0;
                    hold_data_d = pix_data;
                    hold_vld_d  = 1'b1;
                    hold_sof_d  = 1'b0;
                    pend_eol_d  = pix_last;
                end else if (pix_last && hold_vld_q) begin
                    push_req   = 1'b1;
                    push_eol   = 1'b1;
                    hold_vld_d = 1'b0;
                end
            end
            DROP: begin
                hold_vld_d = 1'b0;
                pend_eol_d = 1'b0;
                if (vsync) state_d = BLANK;
            end
            default: begin
                state_d = WAIT_VS;
            end
        endcase

        // No room: abandon the rest of the frame rather than emit a hole.
        if (push_req && !push_ok) begin
            hold_vld_d = 1'b0;
            pend_eol_d = 1'b0;
            drop_d     = 1'b1;
            state_d    = DROP;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_VS;
            vsync_q     <= 1'b0;
            hold_data_q <= '0;
            hold_vld_q  <= 1'b0;
            hold_sof_q  <= 1'b0;
            pend_eol_q  <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vsync_q     <= vsync_d;
            hold_data_q <= hold_data_d;
            hold_vld_q  <= hold_vld_d;
            hold_sof_q  <= hold_sof_d;
            pend_eol_q  <= pend_eol_d;
            drop_q      <= drop_d;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W + 2),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk     (pclk),
        .rst_n   (rst_n),
        .wr_en   (push_req & push_ok),
        .wr_data ({hold_sof_q, push_eol, hold_data_q}),
        .full    (fifo_full),
        .rd_en   (m_axis_tready),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty)
    );

    assign m_axis_tvalid = ~fifo_empty;
    assign m_axis_tuser  = fifo_rd_data[DATA_W+1];
    assign m_axis_tlast  = fifo_rd_data[DATA_W];
    assign m_axis_tdata  = fifo_rd_data[DATA_W-1:0];
    assign frame_dropped = drop_q;

`ifdef CAM_BRIDGE_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q + 16'(fifo_pop & m_axis_tuser);
        drop_cnt_d  = drop_cnt_q;
        if (drop_q && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`endif

endmodule
